// File: rtl/axil_pkg.sv
// Shared types for the AXI4-Lite initiator: response codes, FSM states and
// the default protection value driven on AxPROT.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_B,
    RD_A,
    RD_R,
    RSP
  } axil_mst_state_t;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axil_master.sv
// AXI4-Lite initiator: turns a single-beat cmd/rsp handshake into one AXI-Lite
// read or write, with exactly one transaction in flight.
module axil_master
  import axil_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32,
  parameter logic [2:0] PROT   = PROT_DEFAULT,
  localparam int        STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rstn,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [STRB_W-1:0] cmd_wstrb,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,

  output logic [ADDR_W-1:0] cbus_awaddr,
  output logic [2:0]        cbus_awprot,
  output logic              cbus_awvalid,
  input  logic              cbus_awready,
  output logic [DATA_W-1:0] cbus_wdata,
  output logic [STRB_W-1:0] cbus_wstrb,
  output logic              cbus_wvalid,
  input  logic              cbus_wready,
  input  logic [1:0]        cbus_bresp,
  input  logic              cbus_bvalid,
  output logic              cbus_bready,
  output logic [ADDR_W-1:0] cbus_araddr,
  output logic [2:0]        cbus_arprot,
  output logic              cbus_arvalid,
  input  logic              cbus_arready,
  input  logic [DATA_W-1:0] cbus_rdata,
  input  logic [1:0]        cbus_rresp,
  input  logic              cbus_rvalid,
  output logic              cbus_rready
);

  axil_mst_state_t state;
  logic aw_done, w_done;
  logic aw_hs, w_hs;

  assign cmd_ready   = (state == IDLE);
  assign cbus_awprot = PROT;
  assign cbus_arprot = PROT;
  assign aw_hs       = cbus_awvalid & cbus_awready;
  assign w_hs        = cbus_wvalid  & cbus_wready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      cbus_awaddr  <= '0;
      cbus_awvalid <= 1'b0;
      cbus_wdata   <= '0;
      cbus_wstrb   <= '0;
      cbus_wvalid  <= 1'b0;
      cbus_bready  <= 1'b0;
      cbus_araddr  <= '0;
      cbus_arvalid <= 1'b0;
      cbus_rready  <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_we       <= 1'b0;
      rsp_rdata    <= '0;
      rsp_resp     <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          if (cmd_we) begin
            cbus_awaddr  <= cmd_addr;
            cbus_wdata   <= cmd_wdata;
            cbus_wstrb   <= cmd_wstrb;
            cbus_awvalid <= 1'b1;
            cbus_wvalid  <= 1'b1;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            state        <= WR;
          end else begin
            cbus_araddr  <= cmd_addr;
            cbus_arvalid <= 1'b1;
            state        <= RD_A;
          end
        end
        // AW and W complete independently; B is only opened once both have.
        WR: begin
          if (aw_hs) begin
            cbus_awvalid <= 1'b0;
            aw_done      <= 1'b1;
          end
          if (w_hs) begin
            cbus_wvalid <= 1'b0;
            w_done      <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            cbus_bready <= 1'b1;
            state       <= WR_B;
          end
        end
        WR_B: if (cbus_bvalid) begin
          cbus_bready <= 1'b0;
          rsp_valid   <= 1'b1;
          rsp_we      <= 1'b1;
          rsp_rdata   <= '0;
          rsp_resp    <= cbus_bresp;
          state       <= RSP;
        end
        RD_A: if (cbus_arready) begin
          cbus_arvalid <= 1'b0;
          cbus_rready  <= 1'b1;
          state        <= RD_R;
        end
        RD_R: if (cbus_rvalid) begin
          cbus_rready <= 1'b0;
          rsp_valid   <= 1'b1;
          rsp_we      <= 1'b0;
          rsp_rdata   <= cbus_rdata;
          rsp_resp    <= cbus_rresp;
          state       <= RSP;
        end
        RSP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
